// File: rtl/gpu_pkg.sv
// Shared GPU definitions: opcodes, default field widths, sequencer states.
package gpu_pkg;

   localparam int GPU_CODE_W  = 4;
   localparam int GPU_INDEX_W = 8;
   localparam int GPU_DATA_W  = 23;

   localparam logic [3:0] OP_NOP        = 4'd0;
   localparam logic [3:0] OP_SPRITE_SEL = 4'd1;
   localparam logic [3:0] OP_SPRITE_X   = 4'd2;
   localparam logic [3:0] OP_SPRITE_Y   = 4'd3;
   localparam logic [3:0] OP_SPRITE_H   = 4'd4;
   localparam logic [3:0] OP_SPRITE_W   = 4'd5;

   typedef enum logic [1:0] {
      SEQ_IDLE,
      SEQ_DELAY,
      SEQ_ISSUE,
      SEQ_DONE
   } seq_state_e;

endpackage

// File: rtl/seq_program_ram.sv
// Program store: one write port, one registered read port, no reset.
module seq_program_ram #(
   parameter  int DEPTH = 16,
   parameter  int WIDTH = 35,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             clk_i,
   input  logic             we_i,
   input  logic [AW-1:0]    waddr_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             re_i,
   input  logic [AW-1:0]    raddr_i,
   output logic [WIDTH-1:0] rdata_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] rdata_q;

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
      if (re_i) begin
         rdata_q <= mem_q[raddr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/gpu_instruction_sequencer.sv
// Programmable GPU instruction sequencer with start delay, loop and abort.
// Optional SEQ_GAP_EN adds GapCycles: idle cycles inserted after each transfer.
module gpu_instruction_sequencer
   import gpu_pkg::*;
#(
   parameter  int CODE_W      = GPU_CODE_W,
   parameter  int INDEX_W     = GPU_INDEX_W,
   parameter  int DATA_W      = GPU_DATA_W,
   parameter  int DEPTH       = 16,
   parameter  int START_DELAY = 33,
   localparam int INSTR_W     = CODE_W + INDEX_W + DATA_W,
   localparam int ADDR_W      = $clog2(DEPTH)
) (
   input  logic               Clk,
   input  logic               Reset_n,
   input  logic               ProgWrEn,
   input  logic [ADDR_W-1:0]  ProgAddr,
   input  logic [INSTR_W-1:0] ProgData,
   input  logic [ADDR_W:0]    ProgLength,
   input  logic               Start,
   input  logic               Stop,
   input  logic               LoopEn,
`ifdef SEQ_GAP_EN
   input  logic [7:0]         GapCycles,
`endif
   output logic [INSTR_W-1:0] Instruction,
   output logic               InstrValid,
   input  logic               InstrReady,
   output logic               Busy,
   output logic               Done,
   output logic [7:0]         LoopCount
);

   localparam int LEN_W = ADDR_W + 1;
   localparam int DLY_W = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;
   localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(DEPTH);
   localparam logic [DLY_W-1:0] DLY_LOAD =
      DLY_W'((START_DELAY > 0) ? START_DELAY - 1 : 0);

   seq_state_e         state_q, state_d;
   logic [ADDR_W-1:0]  pc_q, pc_d;
   logic [DLY_W-1:0]   dly_q, dly_d;
   logic               valid_q, valid_d;
   logic [7:0]         loop_q, loop_d;
`ifdef SEQ_GAP_EN
   logic [7:0]         gap_q, gap_d;
`endif

   logic [LEN_W-1:0]   len_c;
   logic [LEN_W-1:0]   pc_cnt;
   logic               last;
   logic [ADDR_W-1:0]  pc_nxt;
   logic               xfer;
   logic               prog_we;
   logic               rd_en;
   logic [ADDR_W-1:0]  rd_addr;
   logic [INSTR_W-1:0] rd_data;

   assign len_c   = (ProgLength > LEN_MAX) ? LEN_MAX : ProgLength;
   assign pc_cnt  = {1'b0, pc_q} + LEN_W'(1);
   // >= rather than == so a length shrunk below PC mid-run still ends
   assign last    = (pc_cnt >= len_c);
   assign pc_nxt  = last ? '0 : pc_cnt[ADDR_W-1:0];
   assign xfer    = valid_q && InstrReady;
   assign prog_we = ProgWrEn &&
                    ((state_q == SEQ_IDLE) || (state_q == SEQ_DONE));

   seq_program_ram #(
      .DEPTH (DEPTH),
      .WIDTH (INSTR_W)
   ) u_ram (
      .clk_i   (Clk),
      .we_i    (prog_we),
      .waddr_i (ProgAddr),
      .wdata_i (ProgData),
      .re_i    (rd_en),
      .raddr_i (rd_addr),
      .rdata_o (rd_data)
   );

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      dly_d   = dly_q;
      valid_d = valid_q;
      loop_d  = loop_q;
`ifdef SEQ_GAP_EN
      gap_d   = gap_q;
`endif
      rd_en   = 1'b0;
      rd_addr = pc_q;

      unique case (state_q)
         SEQ_IDLE: begin
            if (Start) begin
               if (len_c == '0) begin
                  state_d = SEQ_DONE;
               end else begin
                  pc_d    = '0;
                  loop_d  = '0;
                  valid_d = 1'b0;
                  dly_d   = DLY_LOAD;
`ifdef SEQ_GAP_EN
                  gap_d   = '0;
`endif
                  state_d = (START_DELAY == 0) ? SEQ_ISSUE : SEQ_DELAY;
               end
            end
         end
         SEQ_DELAY: begin
            if (Stop) begin
               state_d = SEQ_IDLE;
            end else if (dly_q == '0) begin
               state_d = SEQ_ISSUE;
            end else begin
               dly_d = dly_q - DLY_W'(1);
            end
         end
         SEQ_ISSUE: begin
            if (valid_q) begin
               if (xfer) begin
                  if (last && !LoopEn) begin
                     valid_d = 1'b0;
                     state_d = SEQ_DONE;
                  end else begin
                     pc_d = pc_nxt;
                     if (last) begin
                        loop_d = loop_q + 8'd1;
                     end
`ifdef SEQ_GAP_EN
                     if (GapCycles != 8'd0) begin
                        valid_d = 1'b0;
                        gap_d   = GapCycles - 8'd1;
                     end else begin
                        rd_en   = 1'b1;
                        rd_addr = pc_nxt;
                     end
`else
                     rd_en   = 1'b1;
                     rd_addr = pc_nxt;
`endif
                  end
               end
`ifdef SEQ_GAP_EN
            end else if (gap_q != 8'd0) begin
               gap_d = gap_q - 8'd1;
`endif
            end else begin
               // idle slot: fetch the entry at PC and present it next cycle
               rd_en   = 1'b1;
               rd_addr = pc_q;
               valid_d = 1'b1;
            end
            if (Stop) begin
               valid_d = 1'b0;
               state_d = SEQ_IDLE;
            end
         end
         SEQ_DONE: begin
            state_d = SEQ_IDLE;
         end
         default: begin
            state_d = SEQ_IDLE;
         end
      endcase
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q <= SEQ_IDLE;
         pc_q    <= '0;
         dly_q   <= '0;
         valid_q <= 1'b0;
         loop_q  <= '0;
`ifdef SEQ_GAP_EN
         gap_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         dly_q   <= dly_d;
         valid_q <= valid_d;
         loop_q  <= loop_d;
`ifdef SEQ_GAP_EN
         gap_q   <= gap_d;
`endif
      end
   end

   assign Instruction = valid_q ? rd_data : '0;
   assign InstrValid  = valid_q;
   assign Busy        = (state_q == SEQ_DELAY) || (state_q == SEQ_ISSUE);
   assign Done        = (state_q == SEQ_DONE);
   assign LoopCount   = loop_q;

endmodule

// File: tb/tb_gpu_instruction_sequencer.sv
// Scoreboard bench for gpu_instruction_sequencer (default parameters).
module tb_gpu_instruction_sequencer;
   import gpu_pkg::*;

   logic        Clk = 1'b0;
   logic        Reset_n = 1'b0;
   logic        ProgWrEn = 1'b0;
   logic [3:0]  ProgAddr = '0;
   logic [34:0] ProgData = '0;
   logic [4:0]  ProgLength = '0;
   logic        Start = 1'b0;
   logic        Stop = 1'b0;
   logic        LoopEn = 1'b0;
   logic        InstrReady = 1'b1;
`ifdef SEQ_GAP_EN
   logic [7:0]  GapCycles = '0;
`endif
   logic [34:0] Instruction;
   logic        InstrValid;
   logic        Busy;
   logic        Done;
   logic [7:0]  LoopCount;

   gpu_instruction_sequencer dut (
      .Clk         (Clk),
      .Reset_n     (Reset_n),
      .ProgWrEn    (ProgWrEn),
      .ProgAddr    (ProgAddr),
      .ProgData    (ProgData),
      .ProgLength  (ProgLength),
      .Start       (Start),
      .Stop        (Stop),
      .LoopEn      (LoopEn),
`ifdef SEQ_GAP_EN
      .GapCycles   (GapCycles),
`endif
      .Instruction (Instruction),
      .InstrValid  (InstrValid),
      .InstrReady  (InstrReady),
      .Busy        (Busy),
      .Done        (Done),
      .LoopCount   (LoopCount)
   );

   always #5 Clk = ~Clk;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int xfer_cnt = 0;
   int done_cnt = 0;
   int xfer_cyc[$];
   logic [34:0] sb[$];
   logic [34:0] prog[16];
   bit rdy_toggle = 1'b0;
   logic [3:0] pat = 4'b1001;

   always @(posedge Clk) cyc <= cyc + 1;

   function automatic logic [34:0] mk(input logic [3:0] c,
                                      input logic [7:0] i,
                                      input logic [22:0] d);
      return {c, i, d};
   endfunction

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // ready pattern 1,0,0,1 when toggling, else always ready
   initial begin
      int ph = 0;
      forever begin
         @(posedge Clk);
         #1;
         InstrReady = rdy_toggle ? pat[ph % 4] : 1'b1;
         ph++;
      end
   end

   // monitor: pops expected word on every transfer, checks stall hold
   logic        pv = 1'b0;
   logic        pr = 1'b0;
   logic [34:0] pw = '0;
   always @(negedge Clk) begin
      if (Reset_n) begin
         if (pv && !pr) begin
            chk("hold_valid", InstrValid, 1);
            chk("hold_word", Instruction, pw);
         end
         if (!InstrValid) begin
            chk("nop_when_invalid", Instruction, 0);
         end else if (InstrReady) begin
            xfer_cnt++;
            xfer_cyc.push_back(cyc);
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL xfer_unexpected: got %0h expected none",
                        Instruction);
            end else begin
               chk("xfer_word", Instruction, sb.pop_front());
            end
         end
         if (Done) done_cnt++;
      end
      pv = InstrValid;
      pr = InstrReady;
      pw = Instruction;
   end

   task automatic push_n(input int n, input int len);
      for (int i = 0; i < n; i++) sb.push_back(prog[i % len]);
   endtask

   task automatic pulse_start();
      Start = 1'b1;
      @(posedge Clk);
      #1;
      Start = 1'b0;
   endtask

   task automatic wait_idle(input string nm, input int budget);
      int n = 0;
      while ((Busy || Done) && n < budget) begin
         @(posedge Clk);
         #1;
         n++;
      end
      chk({nm, "_timeout"}, n < budget, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int x0, d0, n;
      logic [2:0] e;

      prog[0] = mk(OP_SPRITE_SEL, 8'd0, 23'd5);
      prog[1] = mk(OP_SPRITE_X, 8'd0, 23'd0);
      prog[2] = mk(OP_SPRITE_Y, 8'd0, 23'd0);
      prog[3] = mk(OP_SPRITE_H, 8'd0, 23'd40);
      prog[4] = mk(OP_SPRITE_W, 8'd0, 23'd30);
      for (int i = 5; i < 16; i++) prog[i] = mk(OP_NOP, 8'(i), 23'(i * 7));

      repeat (3) @(posedge Clk);
      #1;
      chk("rst_valid", InstrValid, 0);
      chk("rst_instr", Instruction, 0);
      chk("rst_busy", Busy, 0);
      chk("rst_done", Done, 0);
      chk("rst_loop", LoopCount, 0);
      Reset_n = 1'b1;
      @(posedge Clk);
      #1;

      for (int i = 0; i < 16; i++) begin
         ProgWrEn = 1'b1;
         ProgAddr = 4'(i);
         ProgData = prog[i];
         @(posedge Clk);
         #1;
      end
      ProgWrEn = 1'b0;

      // exact timing, L=5, always ready
      ProgLength = 5'd5;
      x0 = xfer_cnt;
      d0 = done_cnt;
      push_n(5, 5);
      pulse_start();
      for (int k = 0; k < 42; k++) begin
         @(negedge Clk);
         e = {(k >= 34 && k <= 38), (k == 39), (k < 39)};
         chk($sformatf("timing_k%0d", k), {InstrValid, Done, Busy}, e);
      end
      @(posedge Clk);
      #1;
      chk("basic_xfers", xfer_cnt - x0, 5);
      chk("basic_done", done_cnt - d0, 1);
      chk("basic_sb_empty", sb.size(), 0);

      // stalls with ready 1,0,0,1
      rdy_toggle = 1'b1;
      x0 = xfer_cnt;
      d0 = done_cnt;
      push_n(5, 5);
      pulse_start();
      wait_idle("stall", 300);
      rdy_toggle = 1'b0;
      chk("stall_xfers", xfer_cnt - x0, 5);
      chk("stall_done", done_cnt - d0, 1);
      chk("stall_sb_empty", sb.size(), 0);

      // looping, L=3, stop after 10 transfers
      @(posedge Clk);
      #1;
      ProgLength = 5'd3;
      LoopEn = 1'b1;
      x0 = xfer_cnt;
      d0 = done_cnt;
      push_n(11, 3);
      pulse_start();
      n = 0;
      while ((xfer_cnt - x0) < 10 && n < 200) begin
         @(posedge Clk);
         #2;
         n++;
      end
      chk("loop_timeout", n < 200, 1);
      chk("loop_count", LoopCount, 3);
      chk("loop_no_done", done_cnt - d0, 0);
      Stop = 1'b1;
      @(posedge Clk);
      #1;
      Stop = 1'b0;
      chk("stop_valid", InstrValid, 0);
      chk("stop_instr", Instruction, 0);
      chk("stop_busy", Busy, 0);
      repeat (3) @(posedge Clk);
      #1;
      chk("stop_no_done", done_cnt - d0, 0);
      chk("stop_xfers", xfer_cnt - x0, 11);
      chk("stop_sb_empty", sb.size(), 0);
      LoopEn = 1'b0;

      // zero length
      ProgLength = 5'd0;
      x0 = xfer_cnt;
      d0 = done_cnt;
      pulse_start();
      chk("len0_done_hi", Done, 1);
      chk("len0_busy", Busy, 0);
      @(posedge Clk);
      #1;
      chk("len0_done_lo", Done, 0);
      chk("len0_xfers", xfer_cnt - x0, 0);
      chk("len0_done_cnt", done_cnt - d0, 1);

      // writes while busy must be dropped
      ProgLength = 5'd5;
      x0 = xfer_cnt;
      push_n(5, 5);
      pulse_start();
      for (int i = 0; i < 2; i++) begin
         ProgWrEn = 1'b1;
         ProgAddr = 4'(i);
         ProgData = 35'h7_5A5A_5A5A;
         @(posedge Clk);
         #1;
      end
      ProgWrEn = 1'b0;
      wait_idle("wrbusy", 200);
      push_n(5, 5);
      pulse_start();
      wait_idle("wrbusy2", 200);
      chk("wrbusy_xfers", xfer_cnt - x0, 10);
      chk("wrbusy_sb_empty", sb.size(), 0);

      // length above depth clamps to 16
      ProgLength = 5'd20;
      x0 = xfer_cnt;
      push_n(16, 16);
      pulse_start();
      wait_idle("clamp", 200);
      chk("clamp_xfers", xfer_cnt - x0, 16);
      chk("clamp_sb_empty", sb.size(), 0);

`ifdef SEQ_GAP_EN
      ProgLength = 5'd5;
      GapCycles = 8'd2;
      xfer_cyc.delete();
      push_n(5, 5);
      pulse_start();
      wait_idle("gap2", 300);
      chk("gap2_n", xfer_cyc.size(), 5);
      for (int i = 1; i < xfer_cyc.size(); i++)
         chk($sformatf("gap2_space%0d", i), xfer_cyc[i] - xfer_cyc[i-1], 3);
      GapCycles = 8'd0;
      xfer_cyc.delete();
      push_n(5, 5);
      pulse_start();
      wait_idle("gap0", 300);
      chk("gap0_n", xfer_cyc.size(), 5);
      for (int i = 1; i < xfer_cyc.size(); i++)
         chk($sformatf("gap0_space%0d", i), xfer_cyc[i] - xfer_cyc[i-1], 1);
`endif

      // asynchronous reset in the middle of issue
      ProgLength = 5'd16;
      LoopEn = 1'b1;
      x0 = xfer_cnt;
      push_n(16, 16);
      pulse_start();
      n = 0;
      while ((xfer_cnt - x0) < 3 && n < 200) begin
         @(posedge Clk);
         #2;
         n++;
      end
      chk("rstmid_timeout", n < 200, 1);
      chk("rstmid_pre_busy", Busy, 1);
      Reset_n = 1'b0;
      #1;
      chk("rstmid_valid", InstrValid, 0);
      chk("rstmid_instr", Instruction, 0);
      chk("rstmid_busy", Busy, 0);
      chk("rstmid_loop", LoopCount, 0);
      sb.delete();
      LoopEn = 1'b0;
      @(posedge Clk);
      #1;
      Reset_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge Clk);
         #1;
         chk("post_rst_idle", {InstrValid, Busy, Done}, 3'b000);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/gpu_instruction_sequencer.md
Name: gpu_instruction_sequencer

Overview:
Parametrised, programmable successor to the fixed test-instruction generator. It holds a small program of GPU instructions ({code, index, data}), loaded at run time through a write port. On Start, and after a programmable start delay, it plays the program to the GPU over a valid/ready handshake, with optional looping and abort. It is used as the GPU's bench/bring-up stimulus source and as a boot-time sprite initialiser.

Parameters:
CODE_W, 4, opcode field width
INDEX_W, 8, sprite/register index field width
DATA_W, 23, data field width
DEPTH, 16, program entries (power of 2, at least 2)
START_DELAY, 33, idle cycles between Start and first issue (0 allowed)
INSTR_W, CODE_W+INDEX_W+DATA_W (35), derived; not overridable
ADDR_W, $clog2(DEPTH), derived

Ports:
Clk  in  1  system clock, all logic on posedge
Reset_n  in  1  asynchronous active-low reset
ProgWrEn  in  1  program write strobe
ProgAddr  in  ADDR_W  program write address
ProgData  in  INSTR_W  program write data {code, index, data}
ProgLength  in  ADDR_W+1  number of entries to play; values above DEPTH clamp to DEPTH
Start  in  1  start playback (level sampled per cycle)
Stop  in  1  synchronous abort
LoopEn  in  1  restart at entry 0 after the last entry
Instruction  out  INSTR_W  instruction; all-zero (NOP) whenever InstrValid=0
InstrValid  out  1  Instruction is valid
InstrReady  in  1  consumer accepts; a transfer happens when InstrValid and InstrReady are both 1
Busy  out  1  high in DELAY and ISSUE states
Done  out  1  one-cycle pulse on normal completion
LoopCount  out  8  completed passes; wraps at 255

Behaviour:
- Reset (async assert, sync release): state IDLE; Instruction=0, InstrValid=0, Busy=0, Done=0, LoopCount=0, PC=0, delay counter=0. Program RAM contents are not reset.
- FSM states are IDLE, DELAY, ISSUE, DONE.
- IDLE: Start=1 with clamped length L>0 loads the delay counter, clears LoopCount, sets PC=0, and goes to DELAY. If START_DELAY=0 it goes directly to ISSUE. Start with L=0 goes to DONE (Done pulses, nothing is issued).
- DELAY: counts START_DELAY cycles, then goes to ISSUE. The first InstrValid rises START_DELAY+1 cycles after the edge that samples Start (34 for the default).
- ISSUE: Instruction=mem[PC] (registered output), InstrValid=1. Instruction must stay stable until the transfer. Program-RAM reads are prefetched so that with InstrReady held at 1 there is one transfer per cycle with no bubbles.
- On a transfer at PC=L-1: if LoopEn=1, PC returns to 0, LoopCount increments, and issuing continues. If LoopEn=0, InstrValid drops on the next edge and the state goes to DONE.
- DONE: Done=1 for exactly one cycle, then IDLE.
- Stop=1 in DELAY or ISSUE: on the next edge the state is IDLE, InstrValid=0, Instruction=0, and Done is not pulsed. If a transfer occurs in the same cycle as Stop, that transfer counts, but nothing further is issued.
- Start while Busy is ignored. Stop in IDLE or DONE is ignored.
- ProgWrEn is honoured only in IDLE or DONE. While Busy, writes are dropped silently so the running program is never corrupted.
- ProgLength and LoopEn are sampled continuously. A change mid-run takes effect at the next end-of-program check.
- Reset asserted mid-run aborts immediately to the reset values.

Optional Feature:
SEQ_GAP_EN
- Defined: adds input port GapCycles [7:0]. After each transfer, InstrValid is held 0 (Instruction=NOP) for GapCycles cycles before the next entry is presented. This gap is inserted between loop passes too. GapCycles=0 behaves as back-to-back issue.
- Undefined: the port is absent and issue is back-to-back.

Decomposition:
- Shared package gpu_pkg:
  - opcode constants OP_NOP=0, OP_SPRITE_SEL=1, OP_SPRITE_X=2, OP_SPRITE_Y=3, OP_SPRITE_H=4, OP_SPRITE_W=5
  - default field widths
  - the sequencer state enum
- One sub-module, seq_program_ram: DEPTH x INSTR_W, one write port, one synchronous read port, no reset.

Test Plan:
- Reset mid-ISSUE: assert Reset_n=0 -> same cycle InstrValid=0, Instruction=0, Busy=0. After release with Start=0, outputs stay idle.
- Load the 5 sprite entries ({1,0,5}, {2,0,0}, {3,0,0}, {4,0,40}, {5,0,30}), L=5, InstrReady=1, Start at cycle 0 -> valid at cycles 34-38 with exact words, Done at cycle 39, Busy low at cycle 40.
- Same program with InstrReady toggling 1,0,0,1 -> every entry is held stable while stalled, exactly 5 transfers occur in order, and there are no duplicates.
- LoopEn=1, L=3, 10 transfers -> sequence 0,1,2,0,1,2,0,1,2,0, LoopCount=3, Done never pulses. Then Stop -> InstrValid=0 on the next cycle, state IDLE, no Done.
- L=0 Start -> Done pulses 1 cycle with zero transfers. ProgWrEn during Busy -> readback on the next run shows the original contents. L=20 with DEPTH=16 -> 16 transfers.
- With SEQ_GAP_EN defined and GapCycles=2 -> valid pulses spaced 3 cycles apart under InstrReady=1. GapCycles=0 -> back-to-back.
